// File: rtl/qft_cphase_feeder_if.sv
// Handshake and data bundle between the amplitude source, the controlled-phase feeder and the
// complex multiplier. Defining QFT_CPHASE_INVERSE_EN adds the inverse (conjugate phase) select.
interface qft_cphase_feeder_if #(
    parameter int num_qubit      = 3,
    parameter int complexnum_bit = 24,
    parameter int kmax           = 8
);
    localparam int QW = (num_qubit > 1) ? $clog2(num_qubit) : 1;
    localparam int KW = $clog2(kmax + 1);

    logic                             start;
    logic        [QW-1:0]             ctrl_qubit;
    logic        [QW-1:0]             targ_qubit;
    logic        [KW-1:0]             rot_k;
`ifdef QFT_CPHASE_INVERSE_EN
    logic                             inverse;
`endif
    logic                             amp_valid;
    logic                             amp_ready;
    logic signed [complexnum_bit-1:0] amp_real;
    logic signed [complexnum_bit-1:0] amp_imag;
    logic signed [complexnum_bit-1:0] in_real;
    logic signed [complexnum_bit-1:0] in_imag;
    logic signed [complexnum_bit-1:0] const_real;
    logic signed [complexnum_bit-1:0] const_imag;
    logic        [num_qubit-1:0]      out_idx;
    logic                             out_valid;
    logic                             out_ready;
    logic                             busy;
    logic                             done;
    logic                             err;

    modport master (
`ifdef QFT_CPHASE_INVERSE_EN
        output inverse,
`endif
        output start, ctrl_qubit, targ_qubit, rot_k,
        output amp_valid, amp_real, amp_imag, out_ready,
        input  amp_ready, in_real, in_imag, const_real, const_imag,
        input  out_idx, out_valid, busy, done, err
    );

    modport slave (
`ifdef QFT_CPHASE_INVERSE_EN
        input  inverse,
`endif
        input  start, ctrl_qubit, targ_qubit, rot_k,
        input  amp_valid, amp_real, amp_imag, out_ready,
        output amp_ready, in_real, in_imag, const_real, const_imag,
        output out_idx, out_valid, busy, done, err
    );
endinterface

// File: rtl/qft_cphase_feeder.sv
// Controlled-phase operand feeder: streams one pass of 2^num_qubit amplitudes and pairs each with
// its CR_k phase constant. Define QFT_CPHASE_INVERSE_EN to add the conjugate-phase (inverse) select.
module qft_cphase_feeder #(
    parameter int num_qubit      = 3,
    parameter int complexnum_bit = 24,
    parameter int fp_bit         = 22,
    parameter int kmax           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    qft_cphase_feeder_if.slave bus
);
    localparam int CW = complexnum_bit;
    localparam int QW = (num_qubit > 1) ? $clog2(num_qubit) : 1;
    localparam int KW = $clog2(kmax + 1);

    localparam logic [num_qubit-1:0] CNT_LAST = {num_qubit{1'b1}};
    localparam logic [num_qubit-1:0] CNT_ZERO = {num_qubit{1'b0}};
    localparam logic [QW:0]          Q_LIM    = (QW + 1)'(num_qubit);
    localparam logic [KW-1:0]        K_LIM    = KW'(kmax);
    localparam logic [KW-1:0]        K_ZERO   = {KW{1'b0}};
    localparam logic signed [CW-1:0] FX_ZERO  = {CW{1'b0}};
    localparam logic signed [CW-1:0] FX_ONE   = CW'(64'd1 << fp_bit);
    localparam real                  PI       = 3.14159265358979323846;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Power series evaluated only at elaboration; angles never exceed 2*pi so 40 terms is ample.
    function automatic real series(input real x, input logic want_sin);
        real term;
        real sum;
        if (want_sin) begin
            term = x;
        end else begin
            term = 1.0;
        end
        sum = term;
        for (int n = 1; n < 40; n++) begin
            if (want_sin) begin
                term = -term * x * x / real'((2 * n) * (2 * n + 1));
            end else begin
                term = -term * x * x / real'((2 * n - 1) * (2 * n));
            end
            sum = sum + term;
        end
        return sum;
    endfunction

    function automatic integer rom_entry(input int k, input logic want_sin);
        real ang;
        real scale;
        real v;
        ang   = 2.0 * PI;
        scale = 1.0;
        for (int i = 0; i < k; i++) begin
            ang = ang / 2.0;
        end
        for (int i = 0; i < fp_bit; i++) begin
            scale = scale * 2.0;
        end
        v = series(ang, want_sin) * scale;
        if (v >= 0.0) begin
            rom_entry = $rtoi(v + 0.5);
        end else begin
            rom_entry = -$rtoi(0.5 - v);
        end
    endfunction

    logic signed [CW-1:0] rom_re_s [0:kmax];
    logic signed [CW-1:0] rom_im_s [0:kmax];

    for (genvar g = 0; g <= kmax; g++) begin : g_rom
        localparam logic signed [CW-1:0] RE = CW'(rom_entry(g, 1'b0));
        localparam logic signed [CW-1:0] IM = CW'(rom_entry(g, 1'b1));
        assign rom_re_s[g] = RE;
        assign rom_im_s[g] = IM;
    end

    logic [1:0]           state_q,      state_d;
    logic [num_qubit-1:0] cnt_q,        cnt_d;
    logic [QW-1:0]        ctrl_q,       ctrl_d;
    logic [QW-1:0]        targ_q,       targ_d;
    logic [KW-1:0]        k_q,          k_d;
    logic                 inv_q,        inv_d;
    logic signed [CW-1:0] in_real_q,    in_real_d;
    logic signed [CW-1:0] in_imag_q,    in_imag_d;
    logic signed [CW-1:0] const_real_q, const_real_d;
    logic signed [CW-1:0] const_imag_q, const_imag_d;
    logic [num_qubit-1:0] out_idx_q,    out_idx_d;
    logic                 out_valid_q,  out_valid_d;
    logic                 done_q,       done_d;
    logic                 err_q,        err_d;

    logic                 cfg_ok_s;
    logic                 amp_ready_s;
    logic                 xfer_s;
    logic                 inv_in_s;
    logic signed [CW-1:0] rom_re_sel_s;
    logic signed [CW-1:0] rom_im_sel_s;
    logic signed [CW-1:0] const_re_s;
    logic signed [CW-1:0] const_im_s;

`ifdef QFT_CPHASE_INVERSE_EN
    assign inv_in_s = bus.inverse;
`else
    assign inv_in_s = 1'b0;
`endif

    assign cfg_ok_s = (bus.ctrl_qubit != bus.targ_qubit)
                   && ({1'b0, bus.ctrl_qubit} < Q_LIM)
                   && ({1'b0, bus.targ_qubit} < Q_LIM)
                   && (bus.rot_k != K_ZERO)
                   && (bus.rot_k <= K_LIM);

    assign amp_ready_s = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign xfer_s      = bus.amp_valid && amp_ready_s;

    // Phase constant for the index being accepted: controlled indices get ROM[k], others 1.0.
    always_comb begin
        rom_re_sel_s = FX_ONE;
        rom_im_sel_s = FX_ZERO;
        const_re_s   = FX_ONE;
        const_im_s   = FX_ZERO;
        if (k_q <= K_LIM) begin
            rom_re_sel_s = rom_re_s[k_q];
            rom_im_sel_s = inv_q ? (FX_ZERO - rom_im_s[k_q]) : rom_im_s[k_q];
        end else begin
            rom_re_sel_s = FX_ONE;
            rom_im_sel_s = FX_ZERO;
        end
        if (cnt_q[ctrl_q] && cnt_q[targ_q]) begin
            const_re_s = rom_re_sel_s;
            const_im_s = rom_im_sel_s;
        end else begin
            const_re_s = FX_ONE;
            const_im_s = FX_ZERO;
        end
    end

    // Pass sequencing and operand register next-state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        targ_d       = targ_q;
        k_d          = k_q;
        inv_d        = inv_q;
        in_real_d    = in_real_q;
        in_imag_d    = in_imag_q;
        const_real_d = const_real_q;
        const_imag_d = const_imag_q;
        out_idx_d    = out_idx_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && cfg_ok_s) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                    ctrl_d  = bus.ctrl_qubit;
                    targ_d  = bus.targ_qubit;
                    k_d     = bus.rot_k;
                    inv_d   = inv_in_s;
                end else if (bus.start) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    in_real_d    = bus.amp_real;
                    in_imag_d    = bus.amp_imag;
                    const_real_d = const_re_s;
                    const_imag_d = const_im_s;
                    out_idx_d    = cnt_q;
                    out_valid_d  = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_DRAIN: begin
                // The last operand must be taken before the pass can report done.
                if (!out_valid_q || bus.out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    cnt_d       = CNT_ZERO;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = CNT_ZERO;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            ctrl_q       <= {QW{1'b0}};
            targ_q       <= {QW{1'b0}};
            k_q          <= K_ZERO;
            inv_q        <= 1'b0;
            in_real_q    <= FX_ZERO;
            in_imag_q    <= FX_ZERO;
            const_real_q <= FX_ONE;
            const_imag_q <= FX_ZERO;
            out_idx_q    <= CNT_ZERO;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            targ_q       <= targ_d;
            k_q          <= k_d;
            inv_q        <= inv_d;
            in_real_q    <= in_real_d;
            in_imag_q    <= in_imag_d;
            const_real_q <= const_real_d;
            const_imag_q <= const_imag_d;
            out_idx_q    <= out_idx_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.amp_ready  = amp_ready_s;
    assign bus.in_real    = in_real_q;
    assign bus.in_imag    = in_imag_q;
    assign bus.const_real = const_real_q;
    assign bus.const_imag = const_imag_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_qft_cphase_feeder.sv
// Randomized self-checking bench for qft_cphase_feeder against a pass-level reference model.
module tb_qft_cphase_feeder;
    localparam int NQ   = 3;
    localparam int CW   = 24;
    localparam int FP   = 22;
    localparam int KMAX = 8;
    localparam int N    = 1 << NQ;
    localparam logic signed [CW-1:0] ONE = 24'sd4194304;
    localparam real PI = 3.14159265358979323846;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qft_cphase_feeder_if #(.num_qubit(NQ), .complexnum_bit(CW), .kmax(KMAX)) bus ();

    qft_cphase_feeder #(.num_qubit(NQ), .complexnum_bit(CW), .fp_bit(FP), .kmax(KMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    bit                   m_act  = 1'b0;
    int                   m_cnt  = 0;
    int                   m_ctrl = 0;
    int                   m_targ = 0;
    int                   m_k    = 0;
    bit                   m_inv  = 1'b0;
    bit                   m_ov   = 1'b0;
    logic signed [CW-1:0] m_ir   = 24'sd0;
    logic signed [CW-1:0] m_ii   = 24'sd0;
    logic signed [CW-1:0] m_cr   = 24'sd4194304;
    logic signed [CW-1:0] m_ci   = 24'sd0;
    int                   m_idx  = 0;
    bit                   m_done = 1'b0;
    bit                   m_err  = 1'b0;
    bit                   drv_inv = 1'b0;

    logic signed [CW-1:0] pass_re [N];
    logic signed [CW-1:0] pass_im [N];
    logic signed [CW-1:0] obs_cr  [N];
    logic signed [CW-1:0] obs_ci  [N];
    int done_seen;
    int err_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // e^{i*2*pi/2^k} in fixed point, straight from the math library.
    function automatic logic signed [CW-1:0] phase(input int k, input bit want_im);
        real    ang;
        real    v;
        integer r;
        ang = 2.0 * PI / real'(1 << k);
        v   = (want_im ? $sin(ang) : $cos(ang)) * real'(1 << FP);
        r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return r[CW-1:0];
    endfunction

    function automatic bit cfg_ok(input int c, input int t, input int k);
        return (c != t) && (c < NQ) && (t < NQ) && (k >= 1) && (k <= KMAX);
    endfunction

    task automatic expect_const(input int idx, output logic signed [CW-1:0] cr,
                                output logic signed [CW-1:0] ci);
        if ((((idx >> m_ctrl) & 1) == 1) && (((idx >> m_targ) & 1) == 1)) begin
            cr = phase(m_k, 1'b0);
            ci = phase(m_k, 1'b1);
            if (m_inv) ci = -ci;
        end else begin
            cr = ONE;
            ci = 24'sd0;
        end
    endtask

    // One clock: check the handshake, advance the model on the edge, then check every output.
    task automatic step();
        bit pr;
        #1;
        pr = m_act && (m_cnt < N) && (!m_ov || bus.out_ready);
        check("amp_ready", 64'(bus.amp_ready), 64'(pr));
        @(posedge clk);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_act = 1'b0; m_cnt = 0; m_ov = 1'b0; m_idx = 0;
            m_ir = 24'sd0; m_ii = 24'sd0; m_cr = ONE; m_ci = 24'sd0;
        end else if (!m_act) begin
            if (bus.start) begin
                if (cfg_ok(int'(bus.ctrl_qubit), int'(bus.targ_qubit), int'(bus.rot_k))) begin
                    m_act  = 1'b1;
                    m_cnt  = 0;
                    m_ctrl = int'(bus.ctrl_qubit);
                    m_targ = int'(bus.targ_qubit);
                    m_k    = int'(bus.rot_k);
                    m_inv  = drv_inv;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_cnt < N) begin
            if (pr && bus.amp_valid) begin
                m_ir  = pass_re[m_cnt];
                m_ii  = pass_im[m_cnt];
                m_idx = m_cnt;
                expect_const(m_cnt, m_cr, m_ci);
                m_ov  = 1'b1;
                m_cnt++;
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
        end else if (!m_ov || bus.out_ready) begin
            m_ov = 1'b0; m_done = 1'b1; m_act = 1'b0; m_cnt = 0;
        end
        #1;
        check("out_valid",  64'(bus.out_valid),  64'(m_ov));
        check("in_real",    64'(bus.in_real),    64'(m_ir));
        check("in_imag",    64'(bus.in_imag),    64'(m_ii));
        check("const_real", 64'(bus.const_real), 64'(m_cr));
        check("const_imag", 64'(bus.const_imag), 64'(m_ci));
        check("out_idx",    64'(bus.out_idx),    64'(m_idx));
        check("busy",       64'(bus.busy),       64'(m_act));
        check("done",       64'(bus.done),       64'(m_done));
        check("err",        64'(bus.err),        64'(m_err));
        if (bus.done) done_seen++;
        if (bus.err)  err_seen++;
        if (m_ov) begin
            obs_cr[m_idx] = bus.const_real;
            obs_ci[m_idx] = bus.const_imag;
        end
    endtask

    // mode 0: 1.0 amplitudes, streaming; 1: random data, streaming; 2: out_ready 1,0,0,1 stall;
    // 3: random valid/ready plus ignored starts and config churn while busy. abort_at>0 resets mid-pass.
    task automatic run_pass(input int c, input int t, input int k, input int mode, input int abort_at);
        int cyc;
        bit aborted;
        aborted = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mode == 0) begin
                pass_re[i] = ONE;
                pass_im[i] = 24'sd0;
            end else begin
                pass_re[i] = CW'($urandom);
                pass_im[i] = CW'($urandom);
            end
            obs_cr[i] = 24'sd0;
            obs_ci[i] = 24'sd0;
        end
        done_seen = 0;
        err_seen  = 0;
`ifdef QFT_CPHASE_INVERSE_EN
        bus.inverse = drv_inv;
`endif
        bus.ctrl_qubit = 2'(c);
        bus.targ_qubit = 2'(t);
        bus.rot_k      = 4'(k);
        bus.start      = 1'b1;
        bus.amp_valid  = 1'b0;
        bus.out_ready  = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (m_act && cyc < 200) begin
            case (mode)
                2: begin
                    bus.amp_valid = 1'b1;
                    bus.out_ready = !(cyc == 3 || cyc == 4);
                end
                3: begin
                    bus.amp_valid  = ($urandom_range(0, 3) != 0);
                    bus.out_ready  = ($urandom_range(0, 3) != 0);
                    bus.start      = (m_cnt < N) ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.ctrl_qubit = 2'($urandom_range(0, 3));
                    bus.rot_k      = 4'($urandom_range(0, 15));
                end
                default: begin
                    bus.amp_valid = 1'b1;
                    bus.out_ready = 1'b1;
                end
            endcase
            bus.amp_real = (m_cnt < N) ? pass_re[m_cnt] : CW'($urandom);
            bus.amp_imag = (m_cnt < N) ? pass_im[m_cnt] : CW'($urandom);
            if (abort_at > 0 && m_cnt == abort_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            step();
            cyc++;
        end
        bus.start     = 1'b0;
        bus.amp_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("pass_busy_end", 64'(bus.busy), 64'(1'b0));
        check("pass_done_count", 64'(done_seen), 64'((cfg_ok(c, t, k) && !aborted) ? 1 : 0));
        check("pass_err_count", 64'(err_seen), 64'(cfg_ok(c, t, k) ? 0 : 1));
    endtask

    initial begin
        bus.start = 1'b0; bus.ctrl_qubit = 2'd0; bus.targ_qubit = 2'd0; bus.rot_k = 4'd0;
        bus.amp_valid = 1'b0; bus.amp_real = 24'sd0; bus.amp_imag = 24'sd0; bus.out_ready = 1'b1;
`ifdef QFT_CPHASE_INVERSE_EN
        bus.inverse = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            pass_re[i] = 24'sd0; pass_im[i] = 24'sd0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        step();
        rst_n = 1'b1;
        step();

        check("rom_k1_re", 64'(phase(1, 1'b0)), -64'sd4194304);
        check("rom_k1_im", 64'(phase(1, 1'b1)), 64'sd0);
        check("rom_k2_re", 64'(phase(2, 1'b0)), 64'sd0);
        check("rom_k2_im", 64'(phase(2, 1'b1)), 64'sd4194304);
        check("rom_k3_re", 64'(phase(3, 1'b0)), 64'sd2965821);
        check("rom_k3_im", 64'(phase(3, 1'b1)), 64'sd2965821);

        run_pass(0, 1, 2, 0, 0);
        check("p1_idx3_re", 64'(obs_cr[3]), 64'sd0);
        check("p1_idx3_im", 64'(obs_ci[3]), 64'sd4194304);
        check("p1_idx7_im", 64'(obs_ci[7]), 64'sd4194304);
        check("p1_idx2_re", 64'(obs_cr[2]), 64'sd4194304);
        check("p1_idx1_im", 64'(obs_ci[1]), 64'sd0);

        run_pass(2, 0, 3, 1, 0);
        check("p2_idx5_re", 64'(obs_cr[5]), 64'sd2965821);
        check("p2_idx7_im", 64'(obs_ci[7]), 64'sd2965821);
        check("p2_idx6_re", 64'(obs_cr[6]), 64'sd4194304);
        check("p2_idx4_im", 64'(obs_ci[4]), 64'sd0);

        run_pass(1, 2, 4, 2, 0);

        run_pass(1, 1, 2, 0, 0);
        run_pass(0, 1, 0, 0, 0);
        run_pass(0, 1, 9, 0, 0);
        run_pass(3, 0, 2, 0, 0);

        run_pass(0, 2, 5, 0, 4);
        run_pass(0, 2, 5, 1, 0);

        for (int p = 0; p < 24; p++) begin
            run_pass(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 10)), (p % 3 == 0) ? 1 : 3, 0);
        end

`ifdef QFT_CPHASE_INVERSE_EN
        drv_inv = 1'b1;
        run_pass(0, 1, 2, 0, 0);
        check("inv_idx3_re", 64'(obs_cr[3]), 64'sd0);
        check("inv_idx3_im", 64'(obs_ci[3]), -64'sd4194304);
        run_pass(2, 1, 3, 3, 0);
        drv_inv = 1'b0;
        run_pass(2, 1, 3, 3, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/qft_cphase_feeder.md
Name: qft_cphase_feeder

Overview:
- Sequencer directly upstream of the complex multiplier in the QFT state-vector emulator.
- Accepts a stream of 2^num_qubit state amplitudes in basis-index order and applies one controlled-phase gate CR_k(ctrl, targ) per pass.
- For each amplitude it presents a registered operand pair to the multiplier: the amplitude, plus the constant e^{i*2*pi/2^k} when both the control and target bits of the basis index are 1, otherwise 1.0.
- Sign-extended fixed-point format: fp_bit fractional bits.

Parameters:
num_qubit, 3, qubits; pass length N = 2^num_qubit amplitudes
complexnum_bit, 24, signed width of each real/imag component
fp_bit, 22, fractional bits; 1.0 = 2^fp_bit
kmax, 8, largest supported rotation index k

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE
ctrl_qubit  in  $clog2(num_qubit)  control qubit index
targ_qubit  in  $clog2(num_qubit)  target qubit index
rot_k  in  $clog2(kmax+1)  rotation index k
amp_valid  in  1  upstream amplitude valid
amp_ready  out  1  feeder accepts amplitude
amp_real  in  complexnum_bit  amplitude real part
amp_imag  in  complexnum_bit  amplitude imag part
in_real  out  complexnum_bit  operand to multiplier
in_imag  out  complexnum_bit  operand to multiplier
const_real  out  complexnum_bit  phase constant real part
const_imag  out  complexnum_bit  phase constant imag part
out_idx  out  num_qubit  basis index of the presented operand
out_valid  out  1  operand pair valid
out_ready  in  1  downstream accepts
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of pass
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0 except const_real = 2^fp_bit. Index counter 0. Applies mid-pass: the pass is discarded, no done.
- States:
  - IDLE -> RUN on start with valid configuration. Latch ctrl/targ/k; counter = 0.
  - Invalid configuration (ctrl_qubit==targ_qubit, either index >= num_qubit, rot_k==0 or rot_k>kmax): err=1 for one cycle, remain IDLE.
  - RUN: amp_ready = !out_valid || out_ready.
  - Transfer = amp_valid && amp_ready. On a transfer, the next cycle shows: in_* = amp_*, out_idx = counter, out_valid = 1. Counter increments.
  - On the transfer with counter == N-1: go to DRAIN.
  - DRAIN: amp_ready = 0. When out_valid && out_ready: out_valid cleared, done=1 next cycle, go to IDLE.
- Latency: one cycle from transfer to out_valid.
- Full throughput: one amplitude per cycle while out_ready=1.
- out_ready=0 with out_valid=1: all outputs held stable; amp_ready=0.
- Output clear: out_valid drops when out_ready=1 and there is no new transfer.
- Constant selection uses the bits of the accepted index (counter):
  - bit[ctrl] && bit[targ]: const = ROM[k].
  - Otherwise: const = (2^fp_bit, 0).
- ROM[k] = (round(cos(2*pi/2^k)*2^fp_bit), round(sin(2*pi/2^k)*2^fp_bit)), generated at elaboration.
  - Defaults: k=1 -> (-4194304, 0); k=2 -> (0, 4194304); k=3 -> (2965821, 2965821).
- start while busy: ignored.
- A same-cycle start and a done pulse cannot collide, because start is only sampled in IDLE.
- busy = (state != IDLE).
- Counter wraps only via the DRAIN exit; no partial passes.

Optional Feature:
- Macro: QFT_CPHASE_INVERSE_EN.
- When defined:
  - Extra input port inverse (1 bit), latched at start.
  - When the latched value is 1, const_imag of the applied ROM[k] is negated, giving conjugate phases for the inverse QFT.
- When undefined: no inverse port; phases are always the forward phases.

Test Plan:
- Reset then ctrl=0, targ=1, k=2, 8 amplitudes (4194304, 0), out_ready=1 -> const=(0, 4194304) at idx 3 and 7; const=(4194304, 0) elsewhere; done one cycle after the 8th output.
- ctrl=2, targ=0, k=3, amp_valid continuous -> ROM (2965821, 2965821) at idx 5 and 7 only; amp_ready stays 1 throughout; 8 consecutive out_valid cycles.
- out_ready toggled 1,0,0,1 mid-pass -> outputs held during stall, amp_ready=0 while stalled, no amplitude lost or duplicated, idx sequence 0..7.
- start with ctrl=targ=1, or k=0, or k=9 -> err pulse, busy stays 0, no amp_ready.
- rst_n=0 after the 4th transfer -> next cycle out_valid=0, busy=0, no done; a fresh pass then completes normally.
- QFT_CPHASE_INVERSE_EN with inverse=1, k=2 -> const=(0, -4194304) at the controlled indices.
